// File: rtl/memtest_pkg.sv
// Shared types and default sizing for the memory test access sequencer.
// MEMTEST_ACCESS_TIMEOUT_EN adds the TIMEOUT state to the state encoding.
package memtest_pkg;

    localparam int unsigned DEF_DATUM_WIDTH    = 8;
    localparam int unsigned DEF_ADDR_WIDTH     = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned TIMER_W            = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DONE
`ifdef MEMTEST_ACCESS_TIMEOUT_EN
        ,
        TIMEOUT
`endif
    } memtest_access_state_t;

endpackage

// File: rtl/memtest_access_seq_if.sv
// Memory-side bus of the access sequencer: write/read strobes out, responses back.
interface memtest_access_seq_if
    import memtest_pkg::*;
#(
    parameter int unsigned DATUM_WIDTH = DEF_DATUM_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic [DATUM_WIDTH-1:0] o_mem_wdata;
    logic                   o_mem_we;
    logic                   o_mem_re;
    logic                   i_mem_write_ready;
    logic                   i_mem_read_valid;
    logic [DATUM_WIDTH-1:0] i_mem_rdata;

    modport master (
        output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        input  i_mem_write_ready, i_mem_read_valid, i_mem_rdata
    );

    modport slave (
        input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        output i_mem_write_ready, i_mem_read_valid, i_mem_rdata
    );
endinterface

// File: rtl/memtest_access_timer.sv
// Per-phase wait counter: saturates at LIMIT and flags expiry; clear has priority.
module memtest_access_timer
    import memtest_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_async,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [TIMER_W-1:0] cnt_q, cnt_d;

    assign o_expired = (cnt_q == TIMER_W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear)
            cnt_d = '0;
        else if (i_enable && !o_expired)
            cnt_d = cnt_q + TIMER_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async) cnt_q <= '0;
        else             cnt_q <= cnt_d;
    end
endmodule

// File: rtl/memtest_access_seq.sv
// Write-then-readback access sequencer for memory test.
// Optional MEMTEST_ACCESS_TIMEOUT_EN bounds each phase by TIMEOUT_CYCLES wait cycles.
module memtest_access_seq
    import memtest_pkg::*;
#(
    parameter int unsigned DATUM_WIDTH    = DEF_DATUM_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_rst_async,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [DATUM_WIDTH-1:0] i_wdata,
    output logic                   o_busy,
    output logic                   o_memory_write_ready,
    output logic                   o_memory_read_valid,
    output logic [DATUM_WIDTH-1:0] o_rdata,
    output logic                   o_equal,
    output logic                   o_timeout,
    output logic                   o_done,
    memtest_access_seq_if.master   mem
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    memtest_access_state_t  state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATUM_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATUM_WIDTH-1:0] rdata_q, rdata_d;
    logic eq_q, eq_d, we_q, we_d, re_q, re_d, done_q, done_d, rvld_q, rvld_d;

`ifdef MEMTEST_ACCESS_TIMEOUT_EN
    logic tmo_q, tmo_d;
    logic tmr_clear, tmr_enable, tmr_expired;

    // Restart the count on entry to each phase: every IDLE cycle and on WRITE->READ.
    assign tmr_clear  = (state_q == IDLE) || (state_q == WRITE && mem.i_mem_write_ready);
    assign tmr_enable = (state_q == WRITE) || (state_q == READ);

    memtest_access_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .i_clk       (i_clk),
        .i_rst_async (i_rst_async),
        .i_clear     (tmr_clear),
        .i_enable    (tmr_enable),
        .o_expired   (tmr_expired)
    );
    assign o_timeout = tmo_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        eq_d    = eq_q;
        rvld_d  = 1'b0;
        case (state_q)
            IDLE: if (i_req) begin
                state_d = WRITE;
                addr_d  = i_addr;
                wdata_d = i_wdata;
                eq_d    = 1'b0;
            end
            // A response arriving on the limit cycle takes priority over expiry.
            WRITE: begin
                if (mem.i_mem_write_ready) state_d = READ;
`ifdef MEMTEST_ACCESS_TIMEOUT_EN
                else if (tmr_expired)      state_d = TIMEOUT;
`endif
            end
            READ: begin
                if (mem.i_mem_read_valid) begin
                    state_d = DONE;
                    rdata_d = mem.i_mem_rdata;
                    eq_d    = (mem.i_mem_rdata == wdata_q);
                    rvld_d  = 1'b1;
                end
`ifdef MEMTEST_ACCESS_TIMEOUT_EN
                else if (tmr_expired) state_d = TIMEOUT;
`endif
            end
            default: state_d = IDLE;
        endcase
        we_d   = (state_d == WRITE);
        re_d   = (state_d == READ);
        done_d = (state_d == DONE);
`ifdef MEMTEST_ACCESS_TIMEOUT_EN
        tmo_d  = (state_d == TIMEOUT);
        done_d = done_d | tmo_d;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            eq_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            done_q  <= 1'b0;
            rvld_q  <= 1'b0;
`ifdef MEMTEST_ACCESS_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            eq_q    <= eq_d;
            we_q    <= we_d;
            re_q    <= re_d;
            done_q  <= done_d;
            rvld_q  <= rvld_d;
`ifdef MEMTEST_ACCESS_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign o_busy               = (state_q != IDLE);
    assign o_memory_write_ready = (state_q == WRITE) && mem.i_mem_write_ready;
    assign o_memory_read_valid  = rvld_q;
    assign o_rdata              = rdata_q;
    assign o_equal              = eq_q;
    assign o_done               = done_q;
    assign mem.o_mem_addr       = addr_q;
    assign mem.o_mem_wdata      = wdata_q;
    assign mem.o_mem_we         = we_q;
    assign mem.o_mem_re         = re_q;
endmodule

// File: doc/memtest_access_seq.md
MEMTEST_ACCESS_SEQ -- requirements
Module: memtest_access_seq

Interface
REQ-001 Parameter DATUM_WIDTH, default 8, SHALL set the data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the address width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of wait cycles per memory phase (range 1..65535).
REQ-004 i_clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 i_rst_async  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 i_req  in  1  SHALL start one write-then-readback access; sampled only in IDLE.
REQ-007 i_addr  in  ADDR_WIDTH  SHALL be the target address, captured with i_req.
REQ-008 i_wdata  in  DATUM_WIDTH  SHALL be the pattern to write, captured with i_req.
REQ-009 o_busy  out  1  SHALL be high in every state except IDLE.
REQ-010 o_memory_write_ready  out  1  SHALL pulse for one cycle when the memory accepts the write.
REQ-011 o_memory_read_valid  out  1  SHALL pulse for one cycle when readback data is captured.
REQ-012 o_rdata  out  DATUM_WIDTH  SHALL hold the last captured readback datum.
REQ-013 o_equal  out  1  SHALL be high when o_rdata equals the captured pattern; valid from the o_memory_read_valid pulse onward.
REQ-014 o_timeout  out  1  SHALL pulse for one cycle when a phase exceeds TIMEOUT_CYCLES.
REQ-015 o_done  out  1  SHALL pulse for one cycle when an access ends, whether by success or by timeout.
REQ-016 o_mem_addr, o_mem_wdata  out  ADDR_WIDTH / DATUM_WIDTH  SHALL present the captured address and pattern.
REQ-017 o_mem_we, o_mem_re  out  1  SHALL be the write and read requests to memory.
REQ-018 i_mem_write_ready, i_mem_read_valid  in  1; i_mem_rdata  in  DATUM_WIDTH  SHALL be the memory responses.

Function
REQ-019 FSM states: IDLE, WRITE, READ, DONE, TIMEOUT.
REQ-020 IDLE: i_req=1 SHALL capture i_addr/i_wdata, clear the wait counter, and go to WRITE next cycle.
REQ-021 WRITE: o_mem_we=1 with stable addr/data; i_mem_write_ready=1 SHALL pulse o_memory_write_ready in the same cycle and go to READ.
REQ-022 READ: o_mem_re=1; i_mem_read_valid=1 SHALL capture i_mem_rdata into o_rdata, pulse o_memory_read_valid next cycle, and go to DONE.
REQ-023 o_mem_we and o_mem_re SHALL never be high together and SHALL be 0 outside WRITE/READ.
REQ-024 DONE and TIMEOUT SHALL each last one cycle, assert o_done (TIMEOUT also asserts o_timeout), then return to IDLE.
REQ-025 Wait counter SHALL clear on entry to WRITE and to READ, increment each cycle without a response, and force TIMEOUT when it reaches TIMEOUT_CYCLES.
REQ-026 A response in the same cycle the counter reaches its limit SHALL win; no timeout.
REQ-027 Best-case latency from i_req to o_done SHALL be 4 cycles (response on first cycle of each phase).
REQ-028 i_req while busy SHALL be ignored; inputs SHALL not alter captured addr/data mid-access.
REQ-029 o_equal SHALL be a full-width compare; no partial-width masking.

Reset
REQ-030 i_rst_async high SHALL force IDLE immediately, including mid-access; all outputs 0, o_rdata 0, counter 0.
REQ-031 First i_req is accepted on the first rising edge after reset deassertion.

Configuration
REQ-032 With MEMTEST_ACCESS_TIMEOUT_EN defined, REQ-014/025/026 apply.
REQ-033 Without MEMTEST_ACCESS_TIMEOUT_EN, the counter and TIMEOUT state SHALL be absent, waits SHALL be unbounded, and o_timeout SHALL be tied 0.

Structure
REQ-034 Package memtest_pkg SHALL hold the state enum memtest_access_state_t and default width constants.
REQ-035 Wait counter SHALL be the sub-module memtest_access_timer (clear, enable, expired), instantiated only under the macro.

Verification
REQ-036 Immediate responses: i_req, addr 0x0010, data 0xA5, ready/valid on first phase cycle, rdata 0xA5 -> o_done at cycle 4, o_equal=1, o_timeout=0.
REQ-037 Stuck bit: data 0x80, rdata 0x00, write ready after 3 waits -> o_rdata=0x00, o_equal=0, o_done once.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=4): no read valid -> o_timeout and o_done together, o_mem_re drops, back to IDLE.
REQ-039 Boundary: valid on exact limit cycle -> no timeout, o_equal evaluated normally.
REQ-040 Reset mid-READ, then i_req during busy -> immediate IDLE and all outputs 0; second i_req ignored until IDLE.
